// File: rtl/fp_cmp_pipe.sv
// Two-stage pipelined IEEE-754 comparator with optional min/max result.
// Define FP_CMP_MINMAX_EN to build the min/max datapath on op 10/11.
module fp_cmp_pipe #(
   parameter int EW = 8,
   parameter int MW = 23
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             act,
   output logic             rdy,
   input  logic [1:0]       op,
   input  logic [EW+MW:0]   in1,
   input  logic [EW+MW:0]   in2,
   input  logic             ack,
   output logic             done,
   output logic             eq,
   output logic             great,
   output logic             less,
   output logic             unord,
   output logic             inv,
   output logic [EW+MW:0]   res
);
   localparam int W = 1 + EW + MW;
`ifdef FP_CMP_MINMAX_EN
   localparam bit MM = 1'b1;
`else
   localparam bit MM = 1'b0;
`endif

   typedef struct packed {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         a_nan, a_snan, a_zero;
      logic         b_nan, b_snan, b_zero;
   } s1_t;

   // {nan, snan, zero}
   function automatic logic [2:0] cls(input logic [W-1:0] x);
      logic ex1, mnz;
      ex1 = &x[W-2:MW];
      mnz = |x[MW-1:0];
      return {ex1 & mnz, ex1 & mnz & ~x[MW-1], ~|x[W-2:0]};
   endfunction

   logic s1_valid;
   s1_t  s1;
   logic s2_load;

   assign s2_load = !done || ack;
   assign rdy     = !s1_valid || s2_load;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (rdy) begin
         s1_valid <= act;
         if (act) begin
            s1.op <= op;
            s1.a  <= in1;
            s1.b  <= in2;
            {s1.a_nan, s1.a_snan, s1.a_zero} <= cls(in1);
            {s1.b_nan, s1.b_snan, s1.b_zero} <= cls(in2);
         end
      end
   end

   logic         any_nan, both_zero, gt_raw, eq_c, gt_c, lt_c, sig_c, inv_c;
   logic [W-1:0] res_c;

   always_comb begin
      any_nan   = s1.a_nan | s1.b_nan;
      both_zero = s1.a_zero & s1.b_zero;
      if (s1.a[W-1] != s1.b[W-1])
         gt_raw = !s1.a[W-1];
      else if (s1.a[W-1])
         gt_raw = s1.a[W-2:0] < s1.b[W-2:0];
      else
         gt_raw = s1.a[W-2:0] > s1.b[W-2:0];
      eq_c  = !any_nan && (both_zero || s1.a == s1.b);
      gt_c  = !any_nan && !eq_c && gt_raw;
      lt_c  = !any_nan && !eq_c && !gt_raw;
      // Without min/max, op[1] drops out and 11 degrades to a signalling compare.
      sig_c = s1.op[0] & ~(s1.op[1] & MM);
      inv_c = s1.a_snan | s1.b_snan | (sig_c & any_nan);
      res_c = '0;
`ifdef FP_CMP_MINMAX_EN
      if (s1.op[1]) begin
         if (s1.a_nan && s1.b_nan)
            res_c = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
         else if (s1.a_nan)
            res_c = s1.b;
         else if (s1.b_nan)
            res_c = s1.a;
         else if (eq_c)
            res_c = (both_zero && s1.a[W-1] != s1.b[W-1]) ? {~s1.op[0], {(W-1){1'b0}}} : s1.a;
         else if (s1.op[0])
            res_c = gt_c ? s1.a : s1.b;
         else
            res_c = lt_c ? s1.a : s1.b;
      end
`endif
   end

`ifdef FP_CMP_MINMAX_EN
   always_ff @(posedge clk) begin
      if (rst)
         res <= '0;
      else if (s2_load && s1_valid)
         res <= res_c;
   end
`else
   assign res = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         done  <= 1'b0;
         eq    <= 1'b0;
         great <= 1'b0;
         less  <= 1'b0;
         unord <= 1'b0;
         inv   <= 1'b0;
      end else if (s2_load) begin
         done <= s1_valid;
         if (s1_valid) begin
            eq    <= eq_c;
            great <= gt_c;
            less  <= lt_c;
            unord <= any_nan;
            inv   <= inv_c;
         end
      end
   end
endmodule

// File: tb/tb_fp_cmp_pipe.sv
// Scoreboarded bench for fp_cmp_pipe (single precision) plus a half-precision instance.
// Min/max expectations follow FP_CMP_MINMAX_EN when it is defined for the build.
module tb_fp_cmp_pipe;
   logic        clk = 1'b0;
   logic        rst, act, ack, rdy, done, eq, great, less, unord, inv;
   logic [1:0]  op;
   logic [31:0] in1, in2, res;
   logic        hact, hrdy, hdone, heq, hgreat, hless, hunord, hinv;
   logic [1:0]  hop;
   logic [15:0] ha, hb, hres;

   int total = 0;
   int bad   = 0;
   logic [36:0] sb[$];

   always #5 clk = ~clk;

   fp_cmp_pipe dut (.clk(clk), .rst(rst), .act(act), .rdy(rdy), .op(op), .in1(in1), .in2(in2),
      .ack(ack), .done(done), .eq(eq), .great(great), .less(less), .unord(unord), .inv(inv), .res(res));

   fp_cmp_pipe #(.EW(5), .MW(10)) dut_h (.clk(clk), .rst(rst), .act(hact), .rdy(hrdy), .op(hop),
      .in1(ha), .in2(hb), .ack(1'b1), .done(hdone), .eq(heq), .great(hgreat), .less(hless),
      .unord(hunord), .inv(hinv), .res(hres));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Reference: map each operand onto a signed integer key, so ordering is plain integer order.
   function automatic logic [36:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic na, nb, sa, sbn, un, e, g, l, iv, mm, sig;
      logic [31:0] r;
      longint ka, kb;
      na  = a[30:23] == 8'hFF && a[22:0] != 0;
      nb  = b[30:23] == 8'hFF && b[22:0] != 0;
      sa  = na && !a[22];
      sbn = nb && !b[22];
      ka  = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
      kb  = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
      un  = na | nb;
      e   = !un && ka == kb;
      g   = !un && ka > kb;
      l   = !un && ka < kb;
`ifdef FP_CMP_MINMAX_EN
      mm  = o[1];
      sig = o == 2'b01;
`else
      mm  = 1'b0;
      sig = o[0];
`endif
      iv = sa | sbn | (sig & un);
      r  = 32'h0;
      if (mm) begin
         if (na && nb)      r = 32'h7FC00000;
         else if (na)       r = b;
         else if (nb)       r = a;
         else if (e)        r = (ka == 0 && a[31] != b[31]) ? (o[0] ? 32'h0 : 32'h80000000) : a;
         else if (o[0])     r = g ? a : b;
         else               r = l ? a : b;
      end
      return {e, g, l, un, iv, r};
   endfunction

   // Pop on each handshake; while stalled, outputs must hold the head entry.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else if (ack) begin
            chk("result", {eq, great, less, unord, inv, res}, sb.pop_front());
         end else begin
            chk("hold", {eq, great, less, unord, inv, res}, sb[0]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; in1 = a; in2 = b; act = 1'b1;
      #1;
      for (int i = 0; i < 20; i++) begin
         if (rdy) begin
            sb.push_back(model(o, a, b));
            tick();
            act = 1'b0;
            return;
         end
         tick();
      end
      act = 1'b0;
      chk("send_timeout", 1, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
      chk("drain_empty", sb.size(), 0);
   endtask

   // Counts edges from presenting act until done is seen.
   task automatic lat_check(input string tag);
      int n;
      op = 2'b00; in1 = 32'h3F800000; in2 = 32'h40000000; act = 1'b1;
      #1;
      chk({tag, "_rdy"}, rdy, 1);
      sb.push_back(model(2'b00, 32'h3F800000, 32'h40000000));
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         act = 1'b0;
         n++;
         if (done) break;
      end
      chk({tag, "_lat"}, n, 2);
      chk({tag, "_less"}, {eq, great, less, unord, inv}, 5'b00100);
      drain();
   endtask

   initial begin
      rst = 1'b1; act = 1'b0; ack = 1'b1; op = 2'b00; in1 = '0; in2 = '0;
      hact = 1'b0; hop = 2'b00; ha = '0; hb = '0;
      tick(); tick();
      chk("rst_done", done, 0);
      chk("rst_flags", {eq, great, less, unord, inv}, 0);
      chk("rst_res", res, 0);
      rst = 1'b0;
      #1;
      chk("rst_rdy", rdy, 1);

      lat_check("lat0");

      // Directed patterns, back-to-back with ack held high
      send(2'b00, 32'h00000000, 32'h80000000);
      send(2'b10, 32'h00000000, 32'h80000000);
      send(2'b11, 32'h00000000, 32'h80000000);
      send(2'b00, 32'h7FC00000, 32'h3F800000);
      send(2'b01, 32'h7FC00000, 32'h3F800000);
      send(2'b11, 32'h7FC00000, 32'h3F800000);
      send(2'b00, 32'h7F800001, 32'h3F800000);
      send(2'b10, 32'h7FC00000, 32'h7F800001);
      send(2'b00, 32'h7F800000, 32'h7F800000);
      send(2'b00, 32'h00000001, 32'h00000002);
      send(2'b00, 32'h80000001, 32'h80000002);
      send(2'b10, 32'hBF800000, 32'h40000000);
      send(2'b11, 32'hBF800000, 32'h40000000);
      send(2'b01, 32'hFF800000, 32'h7F800000);
      drain();

      // Random mix, biased towards specials and shared values
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         if ($urandom_range(0, 4) == 0) a[30:23] = 8'hFF;
         if ($urandom_range(0, 4) == 0) b[30:0] = 31'h0;
         send(2'($urandom_range(0, 3)), a, b);
      end
      drain();

      // Stall: two accepts fill the pipe, a third offer is ignored
      ack = 1'b0;
      op = 2'b00; in1 = 32'h3F800000; in2 = 32'h40000000; act = 1'b1;
      #1;
      chk("stall_rdy_a", rdy, 1);
      sb.push_back(model(2'b00, 32'h3F800000, 32'h40000000));
      tick();
      in1 = 32'h40400000; in2 = 32'h40400000;
      #1;
      chk("stall_rdy_b", rdy, 1);
      sb.push_back(model(2'b00, 32'h40400000, 32'h40400000));
      tick();
      chk("stall_rdy_low", rdy, 0);
      in1 = 32'hBF800000; in2 = 32'hC0000000;
      tick();
      chk("stall_rdy_low2", rdy, 0);
      chk("stall_done", done, 1);
      chk("stall_inflight", sb.size(), 2);
      act = 1'b0;
      ack = 1'b1;
      send(2'b00, 32'hBF800000, 32'hC0000000);
      send(2'b00, 32'hFF800000, 32'h7F800000);
      drain();

      // Half precision
      hact = 1'b1; ha = 16'hFC00; hb = 16'hBC00;
      tick();
      hact = 1'b0;
      tick();
      chk("half_done", hdone, 1);
      chk("half_inf", {heq, hgreat, hless, hunord, hinv}, 5'b00100);
      hact = 1'b1; ha = 16'h7E00; hb = 16'h7E00;
      tick();
      hact = 1'b0;
      tick();
      chk("half_nan", {heq, hgreat, hless, hunord, hinv}, 5'b00010);

      // Reset with two requests in flight
      ack = 1'b0;
      send(2'b00, 32'h3F800000, 32'h40000000);
      send(2'b00, 32'h40400000, 32'h40400000);
      rst = 1'b1;
      tick();
      sb.delete();
      chk("mrst_done", done, 0);
      chk("mrst_flags", {eq, great, less, unord, inv}, 0);
      chk("mrst_res", res, 0);
      rst = 1'b0;
      ack = 1'b1;
      #1;
      chk("mrst_rdy", rdy, 1);
      lat_check("lat1");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end
endmodule
